// File: rtl/sensor_poll_scheduler.sv
// Round-robin scheduler that hands a shared sensor bus engine to one of four
// requesters, with a free-running 100 kHz tick driving a per-transaction timeout.
module sensor_poll_scheduler #(
    parameter int unsigned DIV           = 10,
    parameter int unsigned TIMEOUT_TICKS = 200
) (
    input  logic       CLK_1MHZ_IN,
    input  logic       RESET,
    input  logic [3:0] REQ,
    input  logic       BUS_DONE,
    output logic [3:0] GRANT,
    output logic       BUS_START,
    output logic [3:0] ACK,
    output logic [3:0] ERR,
    output logic       TICK_100KHZ,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;

    logic        tick;
    logic        done_ev;
    logic        tout_ev;
    logic        found;
    logic [1:0]  pick;
    logic [1:0]  idx;

    // Prescaler runs 1..DIV regardless of FSM state.
    assign tick    = (presc_q == 16'(DIV));
    assign presc_d = tick ? 16'd1 : presc_q + 16'd1;

    // Search upward from the requester after the last owner; i == 4 wraps to last_q itself.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Completion beats a coincident timeout.
    assign done_ev = (state_q == S_WAIT) && BUS_DONE;
    assign tout_ev = (state_q == S_WAIT) && !BUS_DONE && tick &&
                     (({1'b0, tcnt_q} + 9'd1) == 9'(TIMEOUT_TICKS));

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                grant_d = 4'b0000;
                if (found) begin
                    grant_d = 4'b0001 << pick;
                    last_d  = pick;
                    state_d = S_START;
                end
            end
            S_START: begin
                tcnt_d  = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_ev || tout_ev) begin
                    grant_d = 4'b0000;
                    state_d = S_RELEASE;
                end else if (tick) begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_RELEASE: begin
                grant_d = 4'b0000;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 4'b0000;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_1MHZ_IN) begin
        if (RESET) begin
            state_q <= S_IDLE;
            presc_q <= 16'd1;
            tcnt_q  <= 8'd0;
            grant_q <= 4'b0000;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_resp
        assign ACK[gi] = done_ev && (last_q == 2'(gi));
        assign ERR[gi] = tout_ev && (last_q == 2'(gi));
    end

    assign GRANT       = grant_q;
    assign BUS_START   = (state_q == S_START);
    assign TICK_100KHZ = tick;
    assign BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Randomised and directed bench for sensor_poll_scheduler, checked every cycle
// against a transaction-level model of the arbitration and timeout rules.
module tb_sensor_poll_scheduler;

    localparam int DIV = 10;
    localparam int TO  = 3;

    localparam int P_IDLE    = 0;
    localparam int P_START   = 1;
    localparam int P_WAIT    = 2;
    localparam int P_RELEASE = 3;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] REQ;
    logic       BUS_DONE;
    logic [3:0] GRANT;
    logic       BUS_START;
    logic [3:0] ACK;
    logic [3:0] ERR;
    logic       TICK_100KHZ;
    logic       BUSY;

    int n_chk = 0;
    int n_err = 0;

    // Model: phase of the current transaction, its owner, cycles since reset, ticks waited.
    int m_phase = P_IDLE;
    int m_owner = 0;
    int m_last  = 3;
    int m_k     = 0;
    int m_ticks = 0;
    bit m_valid = 0;

    sensor_poll_scheduler #(.DIV(DIV), .TIMEOUT_TICKS(TO)) dut (
        .CLK_1MHZ_IN (clk),
        .RESET       (RESET),
        .REQ         (REQ),
        .BUS_DONE    (BUS_DONE),
        .GRANT       (GRANT),
        .BUS_START   (BUS_START),
        .ACK         (ACK),
        .ERR         (ERR),
        .TICK_100KHZ (TICK_100KHZ),
        .BUSY        (BUSY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_tick_now();
        return (m_k % DIV) == DIV - 1;
    endfunction

    function automatic bit m_timeout_now(input logic done);
        return (m_phase == P_WAIT) && !done && m_tick_now() && (m_ticks + 1 == TO);
    endfunction

    always @(posedge clk) begin
        if (RESET) begin
            m_phase = P_IDLE;
            m_k     = 0;
            m_last  = 3;
            m_owner = 0;
            m_ticks = 0;
            m_valid = 1;
        end else if (m_valid) begin
            case (m_phase)
                P_IDLE: begin
                    if (REQ != 4'b0000) begin
                        for (int i = 1; i <= 4; i++) begin
                            if (REQ[(m_last + i) % 4] && m_phase == P_IDLE) begin
                                m_owner = (m_last + i) % 4;
                                m_phase = P_START;
                            end
                        end
                        m_last = m_owner;
                    end
                end
                P_START: begin
                    m_ticks = 0;
                    m_phase = P_WAIT;
                end
                P_WAIT: begin
                    if (BUS_DONE || m_timeout_now(BUS_DONE)) m_phase = P_RELEASE;
                    else if (m_tick_now()) m_ticks++;
                end
                default: m_phase = P_IDLE;
            endcase
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [3:0] e_grant, e_ack, e_err;
            e_grant = (m_phase == P_START || m_phase == P_WAIT) ? 4'(1 << m_owner) : 4'b0000;
            e_ack   = (m_phase == P_WAIT && BUS_DONE) ? 4'(1 << m_owner) : 4'b0000;
            e_err   = m_timeout_now(BUS_DONE) ? 4'(1 << m_owner) : 4'b0000;
            chk("grant", 32'(GRANT), 32'(e_grant));
            chk("ack", 32'(ACK), 32'(e_ack));
            chk("err", 32'(ERR), 32'(e_err));
            chk("bus_start", 32'(BUS_START), 32'(m_phase == P_START));
            chk("busy", 32'(BUSY), 32'(m_phase != P_IDLE));
            chk("tick", 32'(TICK_100KHZ), 32'(m_tick_now()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rr [5];
        logic [3:0] gr [5];
        int st [5];
        int n, cyc, done_at, nt;
        bit seen;

        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        RESET = 1'b1;
        REQ = 4'b0000;
        BUS_DONE = 1'b0;
        step();
        step();
        RESET = 1'b0;

        // Idle prescaler: ticks on clocks 10, 20, 30 after release.
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk("idle_tick_pos", 32'(TICK_100KHZ), 32'(c == 10 || c == 20 || c == 30));
            chk("idle_grant", 32'(GRANT), 32'h0);
            chk("idle_busy", 32'(BUSY), 32'h0);
        end

        // Single request, completion 5 clocks after launch.
        do_reset();
        REQ = 4'b0001;
        @(negedge clk);
        chk("single_grant_pre", 32'(GRANT), 32'h0);
        step();
        @(negedge clk);
        chk("single_grant", 32'(GRANT), 32'h1);
        chk("single_start", 32'(BUS_START), 32'h1);
        repeat (5) step();
        BUS_DONE = 1'b1;
        REQ = 4'b0000;
        @(negedge clk);
        chk("single_ack", 32'(ACK), 32'h1);
        chk("single_err", 32'(ERR), 32'h0);
        step();
        BUS_DONE = 1'b0;
        @(negedge clk);
        chk("single_release_grant", 32'(GRANT), 32'h0);

        // All four requesting: rotation 0,1,2,3,0.
        do_reset();
        REQ = 4'b1111;
        n = 0;
        cyc = 0;
        done_at = -1;
        while (n < 5 && cyc < 60) begin
            step();
            cyc++;
            BUS_DONE = (cyc == done_at);
            @(negedge clk);
            if (BUS_START) begin
                gr[n] = GRANT;
                st[n] = cyc;
                n++;
                done_at = cyc + 2;
            end
        end
        step();
        BUS_DONE = 1'b0;
        REQ = 4'b0000;
        chk("rr_start_count", 32'(n), 32'd5);
        for (int i = 0; i < n; i++) chk("rr_order", 32'(gr[i]), 32'(exp_rr[i]));
        for (int i = 1; i < n; i++) chk("rr_interval", 32'(st[i] - st[i-1]), 32'd5);

        // Timeout: ERR on the third tick after launch.
        do_reset();
        REQ = 4'b0100;
        step();
        nt = 0;
        seen = 0;
        for (int g = 0; g < 60 && !seen; g++) begin
            step();
            @(negedge clk);
            if (TICK_100KHZ) nt++;
            if (nt == 3 && TICK_100KHZ) begin
                chk("tout_err", 32'(ERR), 32'h4);
                chk("tout_ack", 32'(ACK), 32'h0);
                seen = 1;
            end else begin
                chk("tout_err_early", 32'(ERR), 32'h0);
            end
        end
        chk("tout_seen", 32'(seen), 32'h1);
        step();
        REQ = 4'b0000;
        @(negedge clk);
        chk("tout_release_busy", 32'(BUSY), 32'h1);
        chk("tout_release_grant", 32'(GRANT), 32'h0);
        step();
        @(negedge clk);
        chk("tout_idle_busy", 32'(BUSY), 32'h0);

        // Completion coinciding with the timeout tick: ACK only.
        do_reset();
        REQ = 4'b0100;
        seen = 0;
        for (int g = 0; g < 80 && !seen; g++) begin
            step();
            if (m_timeout_now(1'b0)) begin
                BUS_DONE = 1'b1;
                @(negedge clk);
                chk("tie_ack", 32'(ACK), 32'h4);
                chk("tie_err", 32'(ERR), 32'h0);
                REQ = 4'b0000;
                seen = 1;
            end
        end
        chk("tie_seen", 32'(seen), 32'h1);
        step();
        BUS_DONE = 1'b0;

        // Reset during WAIT abandons the transaction; late BUS_DONE ignored.
        do_reset();
        REQ = 4'b0010;
        repeat (3) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        BUS_DONE = 1'b1;
        REQ = 4'b0011;
        @(negedge clk);
        chk("rst_ack", 32'(ACK), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        chk("rst_grant", 32'(GRANT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        step();
        BUS_DONE = 1'b0;
        @(negedge clk);
        chk("rst_next_grant", 32'(GRANT), 32'h1);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            step();
            RESET = ($urandom_range(399) == 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) REQ[b] = ~REQ[b];
            BUS_DONE = ($urandom_range(((i / 500) % 2 == 1) ? 39 : 5) == 0);
        end
        step();
        RESET = 1'b0;
        BUS_DONE = 1'b0;
        REQ = 4'b0000;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
